// File: rtl/sc_mmio_datamem.sv
// Data memory for the single-cycle CPU: word RAM below 0xFFFFFF00 and an I/O window
// above it with switches, debounced keys, seven-segment digits, LEDs and a cycle timer.
module sc_mmio_datamem #(
    parameter int DEPTH_LOG2 = 5,
    parameter int NUM_HEX    = 6,
    parameter int LED_W      = 10,
    parameter int SW_W       = 10,
    parameter int KEY_W      = 3,
    parameter int DEB_CYCLES = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [31:0]          addr,
    input  logic [31:0]          datain,
    input  logic                 we,
    output logic [31:0]          dataout,
    input  logic [SW_W-1:0]      sw,
    input  logic [KEY_W-1:0]     key,
    output logic [7*NUM_HEX-1:0] hex,
    output logic [LED_W-1:0]     led
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    // I/O register offsets expressed as word indices (addr[7:2])
    localparam logic [5:0] OFF_SW   = 6'd0;
    localparam logic [5:0] OFF_KLVL = 6'd4;
    localparam logic [5:0] OFF_KPRS = 6'd5;
    localparam logic [5:0] OFF_HEX0 = 6'd8;
    localparam logic [5:0] OFF_LED  = 6'd32;
    localparam logic [5:0] OFF_TMR  = 6'd36;

    function automatic logic [6:0] seg7(input logic [4:0] dig);
        logic [6:0] seg;
        if (dig[4]) begin
            seg = 7'b1111111;
        end else begin
            case (dig[3:0])
                4'h0: seg = 7'b1000000;
                4'h1: seg = 7'b1111001;
                4'h2: seg = 7'b0100100;
                4'h3: seg = 7'b0110000;
                4'h4: seg = 7'b0011001;
                4'h5: seg = 7'b0010010;
                4'h6: seg = 7'b0000010;
                4'h7: seg = 7'b1111000;
                4'h8: seg = 7'b0000000;
                4'h9: seg = 7'b0010000;
                4'hA: seg = 7'b0001000;
                4'hB: seg = 7'b0000011;
                4'hC: seg = 7'b1000110;
                4'hD: seg = 7'b0100001;
                4'hE: seg = 7'b0000110;
                4'hF: seg = 7'b0001110;
                default: seg = 7'b1111111;
            endcase
        end
        return seg;
    endfunction

    logic [31:0]           mem_q [DEPTH];
    logic [SW_W-1:0]       sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
    logic [KEY_W-1:0]      key_s1_q, key_s1_d, key_s2_q, key_s2_d;
    logic [KEY_W-1:0]      key_level_q, key_level_d, key_press_q, key_press_d;
    logic [CNT_W-1:0]      deb_cnt_q [KEY_W];
    logic [CNT_W-1:0]      deb_cnt_d [KEY_W];
    logic [4:0]            digit_q [NUM_HEX];
    logic [4:0]            digit_d [NUM_HEX];
    logic [LED_W-1:0]      led_q, led_d;
    logic [31:0]           timer_q, timer_d;
    logic [31:0]           dataout_q, dataout_d;

    logic                  io_s, io_we_s, ram_we_s;
    logic [5:0]            word_off_s;
    logic [DEPTH_LOG2-1:0] ram_idx_s;
    logic [KEY_W-1:0]      key_clr_s;
    logic [31:0]           rd_hex_s, rd_io_s;
    logic                  unused_addr_s;

    assign io_s          = (addr[31:8] == 24'hFFFFFF);
    assign io_we_s       = we & io_s;
    assign ram_we_s      = we & ~io_s;
    assign word_off_s    = addr[7:2];
    assign ram_idx_s     = addr[DEPTH_LOG2+1:2];
    assign unused_addr_s = ^addr[1:0];

    assign dataout = dataout_q;
    assign led     = led_q;

    // RAM array: not reset, read side sees the pre-write word
    always_ff @(posedge clock) begin
        if (ram_we_s) begin
            mem_q[ram_idx_s] <= datain;
        end
    end

    // Next state for synchronisers, debouncers, press latches and writable registers
    always_comb begin
        sw_s1_d     = sw;
        sw_s2_d     = sw_s1_q;
        key_s1_d    = ~key;
        key_s2_d    = key_s1_q;
        key_level_d = key_level_q;
        deb_cnt_d   = deb_cnt_q;
        led_d       = led_q;
        digit_d     = digit_q;
        key_clr_s   = {KEY_W{1'b0}};

        for (int k = 0; k < KEY_W; k++) begin
            if (key_s2_q[k] == key_level_q[k]) begin
                deb_cnt_d[k] = {CNT_W{1'b0}};
            end else if (deb_cnt_q[k] == CNT_LAST) begin
                deb_cnt_d[k]   = {CNT_W{1'b0}};
                key_level_d[k] = key_s2_q[k];
            end else begin
                deb_cnt_d[k] = deb_cnt_q[k] + CNT_W'(1);
            end
        end

        if (io_we_s && word_off_s == OFF_KPRS) begin
            key_clr_s = datain[KEY_W-1:0];
        end else begin
            key_clr_s = {KEY_W{1'b0}};
        end
        // a fresh press edge overrides a simultaneous clear
        key_press_d = (key_press_q & ~key_clr_s) | (key_level_d & ~key_level_q);

        for (int i = 0; i < NUM_HEX; i++) begin
            if (io_we_s && word_off_s == OFF_HEX0 + 6'(i)) begin
                digit_d[i] = datain[4:0];
            end else begin
                digit_d[i] = digit_q[i];
            end
        end

        if (io_we_s && word_off_s == OFF_LED) begin
            led_d = datain[LED_W-1:0];
        end else begin
            led_d = led_q;
        end

        if (io_we_s && word_off_s == OFF_TMR) begin
            timer_d = datain;
        end else begin
            timer_d = timer_q + 32'd1;
        end
    end

    // Load data selection: I/O register or RAM word
    always_comb begin
        rd_hex_s = 32'd0;
        for (int i = 0; i < NUM_HEX; i++) begin
            if (word_off_s == OFF_HEX0 + 6'(i)) begin
                rd_hex_s = 32'(digit_q[i]);
            end else begin
                rd_hex_s = rd_hex_s;
            end
        end

        case (word_off_s)
            OFF_SW:   rd_io_s = 32'(sw_s2_q);
            OFF_KLVL: rd_io_s = 32'(key_level_q);
            OFF_KPRS: rd_io_s = 32'(key_press_q);
            OFF_LED:  rd_io_s = 32'(led_q);
            OFF_TMR:  rd_io_s = timer_q;
            default:  rd_io_s = rd_hex_s;
        endcase

        if (io_s) begin
            dataout_d = rd_io_s;
        end else begin
            dataout_d = mem_q[ram_idx_s];
        end
    end

    // Seven-segment decode of the registered digits
    always_comb begin
        hex = {(7*NUM_HEX){1'b1}};
        for (int i = 0; i < NUM_HEX; i++) begin
            hex[7*i +: 7] = seg7(digit_q[i]);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            sw_s1_q     <= {SW_W{1'b0}};
            sw_s2_q     <= {SW_W{1'b0}};
            key_s1_q    <= {KEY_W{1'b0}};
            key_s2_q    <= {KEY_W{1'b0}};
            key_level_q <= {KEY_W{1'b0}};
            key_press_q <= {KEY_W{1'b0}};
            led_q       <= {LED_W{1'b0}};
            timer_q     <= 32'd0;
            dataout_q   <= 32'd0;
            for (int k = 0; k < KEY_W; k++) begin
                deb_cnt_q[k] <= {CNT_W{1'b0}};
            end
            for (int i = 0; i < NUM_HEX; i++) begin
                digit_q[i] <= 5'h10;
            end
        end else begin
            sw_s1_q     <= sw_s1_d;
            sw_s2_q     <= sw_s2_d;
            key_s1_q    <= key_s1_d;
            key_s2_q    <= key_s2_d;
            key_level_q <= key_level_d;
            key_press_q <= key_press_d;
            led_q       <= led_d;
            timer_q     <= timer_d;
            dataout_q   <= dataout_d;
            deb_cnt_q   <= deb_cnt_d;
            digit_q     <= digit_d;
        end
    end
endmodule

// File: tb/tb_sc_mmio_datamem.sv
// Bench for sc_mmio_datamem: a behavioural model checked every cycle plus directed
// vectors with hand-computed literal expectations.
module tb_sc_mmio_datamem;
    localparam int NUM_HEX = 6;
    localparam int LED_W   = 10;
    localparam int SW_W    = 10;
    localparam int KEY_W   = 3;
    localparam int DEB     = 16;
    localparam int DEPTH   = 32;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [31:0]          addr, datain, dataout;
    logic                 we;
    logic [SW_W-1:0]      sw;
    logic [KEY_W-1:0]     key;
    logic [7*NUM_HEX-1:0] hex;
    logic [LED_W-1:0]     led;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    logic [31:0]      m_ram [DEPTH];
    bit               m_rk [DEPTH];
    logic [31:0]      m_dout, m_tmr;
    bit               m_dknown;
    logic [SW_W-1:0]  m_sw1, m_sw2;
    logic [KEY_W-1:0] m_k1, m_k2, m_lvl, m_press;
    int               m_run [KEY_W];
    int               m_dig [NUM_HEX];
    logic [LED_W-1:0] m_led;
    // lit segments per hex value, bit0 = a ... bit6 = g, active-high
    logic [6:0] lit [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    sc_mmio_datamem dut (
        .clock(clock), .reset(reset), .addr(addr), .datain(datain), .we(we),
        .dataout(dataout), .sw(sw), .key(key), .hex(hex), .led(led)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_step();
        bit               io, known;
        logic [7:0]       o;
        logic [31:0]      rd;
        logic [KEY_W-1:0] nl;
        int               widx;
        io    = (addr[31:8] == 24'hFFFFFF);
        o     = {addr[7:2], 2'b00};
        widx  = int'((addr >> 2) % 32'(DEPTH));
        known = 1'b1;
        rd    = 32'd0;
        if (reset) begin
            m_sw1 = '0; m_sw2 = '0; m_k1 = '0; m_k2 = '0; m_lvl = '0; m_press = '0;
            m_led = '0; m_tmr = 32'd0;
            for (int k = 0; k < KEY_W; k++) m_run[k] = 0;
            for (int i = 0; i < NUM_HEX; i++) m_dig[i] = 16;
        end else begin
            if (!io) begin
                rd = m_ram[widx];
                known = m_rk[widx];
            end else if (o == 8'h00) rd = 32'(m_sw2);
            else if (o == 8'h10) rd = 32'(m_lvl);
            else if (o == 8'h14) rd = 32'(m_press);
            else if (o >= 8'h20 && o < 8'h20 + 8'(4 * NUM_HEX)) rd = 32'(m_dig[int'(o - 8'h20) / 4]);
            else if (o == 8'h80) rd = 32'(m_led);
            else if (o == 8'h90) rd = m_tmr;
            nl = m_lvl;
            for (int k = 0; k < KEY_W; k++) begin
                if (m_k2[k] != m_lvl[k]) begin
                    m_run[k]++;
                    if (m_run[k] == DEB) begin
                        nl[k] = m_k2[k];
                        m_run[k] = 0;
                    end
                end else begin
                    m_run[k] = 0;
                end
            end
            if (io && we && o == 8'h14) m_press = m_press & ~datain[KEY_W-1:0];
            m_press = m_press | (nl & ~m_lvl);
            m_lvl = nl;
            m_k2 = m_k1; m_k1 = ~key;
            m_sw2 = m_sw1; m_sw1 = sw;
            if (io && we && o >= 8'h20 && o < 8'h20 + 8'(4 * NUM_HEX))
                m_dig[int'(o - 8'h20) / 4] = int'(datain[4:0]);
            if (io && we && o == 8'h80) m_led = datain[LED_W-1:0];
            if (io && we && o == 8'h90) m_tmr = datain;
            else m_tmr = m_tmr + 32'd1;
        end
        if (!io && we) begin
            m_ram[widx] = datain;
            m_rk[widx] = 1'b1;
        end
        m_dout = rd;
        m_dknown = known;
    endtask

    function automatic logic [7*NUM_HEX-1:0] exp_hex();
        logic [7*NUM_HEX-1:0] e;
        for (int i = 0; i < NUM_HEX; i++) begin
            if (m_dig[i] > 15) e[7*i +: 7] = 7'h7F;
            else e[7*i +: 7] = ~lit[m_dig[i]];
        end
        return e;
    endfunction

    always @(posedge clock) model_step();

    always @(negedge clock) begin
        if (chk_en) begin
            if (m_dknown) chk("dataout", dataout, m_dout);
            chk("hex", hex, exp_hex());
            chk("led", led, m_led);
        end
    end

    task automatic step(input logic [31:0] a, input logic [31:0] d, input logic w);
        addr = a; datain = d; we = w;
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1; addr = 32'd0; datain = 32'd0; we = 1'b0; sw = 10'h000; key = 3'b111;
        step(32'h0, 32'h0, 1'b0);
        step(32'h0, 32'h0, 1'b0);
        chk_en = 1'b1;
        chk("rst_dout", dataout, 32'h0);
        chk("rst_hex", hex, 42'h3FF_FFFF_FFFF);
        chk("rst_led", led, 10'h0);
        reset = 1'b0;
        sw = 10'h2A5;

        // RAM store/load, I/O isolation, read-during-write, aliasing
        step(32'h0000_0000, 32'h1111_1111, 1'b1);
        step(32'h0000_000C, 32'h0000_02A5, 1'b1);
        step(32'h0000_000C, 32'h0, 1'b0);
        chk("t1_lw3", dataout, 32'h0000_02A5);
        step(32'hFFFF_FF80, 32'h0000_DEAD, 1'b1);
        chk("t1_led", led, 10'h2AD);
        step(32'h0000_0000, 32'h0, 1'b0);
        chk("t1_ram0", dataout, 32'h1111_1111);
        step(32'h0000_000C, 32'h0000_1234, 1'b1);
        chk("t1_rdw_old", dataout, 32'h0000_02A5);
        step(32'h0000_008C, 32'h0, 1'b0);
        chk("t1_alias", dataout, 32'h0000_1234);
        step(32'hFFFF_FF00, 32'h0, 1'b0);
        chk("t1_sw", dataout, 32'h0000_02A5);
        step(32'hFFFF_FF44, 32'h77, 1'b1);
        step(32'hFFFF_FF44, 32'h0, 1'b0);
        chk("t1_unmapped", dataout, 32'h0);

        // seven-segment digits
        step(32'hFFFF_FF24, 32'h5, 1'b1);
        chk("t2_dig1_5", hex[13:7], 7'b0010010);
        step(32'hFFFF_FF24, 32'h10, 1'b1);
        chk("t2_dig1_blank", hex[13:7], 7'b1111111);
        step(32'hFFFF_FF20, 32'h8, 1'b1);
        chk("t2_dig0_8", hex[6:0], 7'b0000000);
        step(32'hFFFF_FF24, 32'h0, 1'b0);
        chk("t2_rd_dig1", dataout, 32'h10);

        // key 0 with glitches, then a clean press and W1C
        for (int g = 0; g < 2; g++) begin
            key[0] = 1'b0;
            for (int i = 0; i < 3; i++) step(32'hFFFF_FF10, 32'h0, 1'b0);
            key[0] = 1'b1;
            for (int i = 0; i < 2; i++) step(32'hFFFF_FF10, 32'h0, 1'b0);
        end
        key[0] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(32'hFFFF_FF10, 32'h0, 1'b0);
            if (i == 9) chk("t3_lvl_early", dataout, 32'h0);
        end
        chk("t3_lvl", dataout, 32'h1);
        step(32'hFFFF_FF14, 32'h0, 1'b0);
        chk("t3_press", dataout, 32'h1);
        step(32'hFFFF_FF14, 32'h1, 1'b1);
        step(32'hFFFF_FF14, 32'h0, 1'b0);
        chk("t3_w1c", dataout, 32'h0);
        key[0] = 1'b1;
        for (int i = 0; i < 20; i++) step(32'hFFFF_FF10, 32'h0, 1'b0);
        chk("t3_release", dataout, 32'h0);

        // W1C on the exact cycle key 1's level rises: the set must win
        key[1] = 1'b0;
        for (int i = 0; i < 17; i++) step(32'hFFFF_FF10, 32'h0, 1'b0);
        step(32'hFFFF_FF14, 32'h2, 1'b1);
        step(32'hFFFF_FF14, 32'h0, 1'b0);
        chk("t4_set_wins", dataout, 32'h2);
        key[1] = 1'b1;
        for (int i = 0; i < 20; i++) step(32'hFFFF_FF10, 32'h0, 1'b0);

        // timer wrap, then reset mid-count and mid-debounce
        step(32'hFFFF_FF90, 32'hFFFF_FFFE, 1'b1);
        step(32'hFFFF_FF90, 32'h0, 1'b0);
        chk("t5_tmr0", dataout, 32'hFFFF_FFFE);
        step(32'hFFFF_FF90, 32'h0, 1'b0);
        chk("t5_tmr1", dataout, 32'hFFFF_FFFF);
        step(32'hFFFF_FF90, 32'h0, 1'b0);
        chk("t5_wrap", dataout, 32'h0);
        step(32'hFFFF_FF80, 32'h3FF, 1'b1);
        step(32'hFFFF_FF20, 32'h3, 1'b1);
        key[2] = 1'b0;
        for (int i = 0; i < 5; i++) step(32'hFFFF_FF90, 32'h0, 1'b0);
        reset = 1'b1;
        step(32'hFFFF_FF90, 32'h0, 1'b0);
        chk("t5_rst_dout", dataout, 32'h0);
        chk("t5_rst_led", led, 10'h0);
        chk("t5_rst_hex", hex, 42'h3FF_FFFF_FFFF);
        reset = 1'b0;
        step(32'hFFFF_FF90, 32'h0, 1'b0);
        chk("t5_tmr_rst", dataout, 32'h0);
        step(32'hFFFF_FF90, 32'h0, 1'b0);
        chk("t5_tmr_inc", dataout, 32'h1);
        for (int i = 0; i < 10; i++) step(32'hFFFF_FF10, 32'h0, 1'b0);
        chk("t5_deb_restart", dataout, 32'h0);
        for (int i = 0; i < 10; i++) step(32'hFFFF_FF10, 32'h0, 1'b0);
        chk("t5_deb_done", dataout, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
